// File: rtl/spi_pkg.sv
// spi_pkg: shared types and parameter defaults for the SPI master datapath.
package spi_pkg;

    localparam int DIV_WIDTH_DEF = 8;
    localparam int LEN_WIDTH_DEF = 5;
    localparam int DLY_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RUN,
        ST_HOLD
    } spi_sckgen_state_e;

endpackage

// File: rtl/spi_sckgen_if.sv
// spi_sckgen_if: control and status bundle between the SPI host logic and the SCK sequencer.
interface spi_sckgen_if
    import spi_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DEF,
    parameter int LEN_WIDTH = LEN_WIDTH_DEF,
    parameter int DLY_WIDTH = DLY_WIDTH_DEF
);
    logic                 start_i;
    logic                 abort_i;
    logic                 cpol_i;
    logic                 cpha_i;
    logic [DIV_WIDTH-1:0] div_i;
    logic [LEN_WIDTH-1:0] len_i;
    logic [DLY_WIDTH-1:0] dly_i;
    logic                 sck_o;
    logic                 cs_n_o;
    logic                 busy_o;
    logic                 sample_o;
    logic                 shift_o;
    logic                 done_o;

    modport master (
        output start_i, abort_i, cpol_i, cpha_i, div_i, len_i, dly_i,
        input  sck_o, cs_n_o, busy_o, sample_o, shift_o, done_o
    );

    modport slave (
        input  start_i, abort_i, cpol_i, cpha_i, div_i, len_i, dly_i,
        output sck_o, cs_n_o, busy_o, sample_o, shift_o, done_o
    );

endinterface

// File: rtl/spi_sckgen_cnt.sv
// spi_sckgen_cnt: reloadable down-counter with a zero flag; load wins over enable,
// and the count holds at zero rather than wrapping.
module spi_sckgen_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !zero) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/spi_sckgen.sv
// spi_sckgen: SPI SCK generator and frame sequencer with CPOL/CPHA-resolved sample/shift strobes.
// Define SPI_SCKGEN_CSDLY_EN to add CS setup/hold delay states driven by dly_i.
module spi_sckgen
    import spi_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DEF,
    parameter int LEN_WIDTH = LEN_WIDTH_DEF,
    parameter int DLY_WIDTH = DLY_WIDTH_DEF
) (
    input logic         clk_i,
    input logic         rst_n_i,
    spi_sckgen_if.slave sif
);

    localparam int EDGE_W = LEN_WIDTH + 2;

    // A frame of len+1 bits has two SCK edges per bit.
    function automatic logic [EDGE_W-1:0] edge_total(input logic [LEN_WIDTH-1:0] len);
        return {1'b0, len, 1'b0} + EDGE_W'(2);
    endfunction

    spi_sckgen_state_e    state;
    logic [EDGE_W-1:0]    edges_left;
    logic                 sck_r;
    logic                 cs_n_r;
    logic                 busy_r;
    logic                 sample_r;
    logic                 shift_r;
    logic                 done_r;
    logic                 cfg_cpha;
    logic [DIV_WIDTH-1:0] cfg_div;
    logic                 start_ok;
    logic                 half_load;
    logic                 half_zero;
    logic [DIV_WIDTH-1:0] half_val;
    logic                 go_setup;
    logic                 go_hold;
    logic                 lead_edge;
    logic                 last_edge;

    assign start_ok  = (state == ST_IDLE) && sif.start_i && !sif.abort_i;
    assign lead_edge = ~edges_left[0];
    assign last_edge = (edges_left == EDGE_W'(1));

    // Kept primed with div_i while idle, so RUN entry needs no separate load.
    assign half_load = (state == ST_IDLE) || ((state == ST_RUN) && half_zero);
    assign half_val  = (state == ST_IDLE) ? sif.div_i : cfg_div;

    spi_sckgen_cnt #(.WIDTH(DIV_WIDTH)) u_half_cnt (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .load     (half_load),
        .en       (state == ST_RUN),
        .load_val (half_val),
        .zero     (half_zero)
    );

    always_ff @(posedge clk_i) begin
        if (start_ok) begin
            cfg_cpha <= sif.cpha_i;
            cfg_div  <= sif.div_i;
        end
    end

`ifdef SPI_SCKGEN_CSDLY_EN
    logic [DLY_WIDTH-1:0] cfg_dly;
    logic [DLY_WIDTH-1:0] dly_val;
    logic                 dly_zero;

    always_ff @(posedge clk_i) begin
        if (start_ok) begin
            cfg_dly <= sif.dly_i;
        end
    end

    assign go_setup = (sif.dly_i != '0);
    assign go_hold  = (cfg_dly != '0);
    // Loaded with dly-1 while idle/running so SETUP and HOLD last exactly dly cycles.
    assign dly_val  = ((state == ST_IDLE) ? sif.dly_i : cfg_dly) - DLY_WIDTH'(1);

    spi_sckgen_cnt #(.WIDTH(DLY_WIDTH)) u_dly_cnt (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .load     ((state == ST_IDLE) || (state == ST_RUN)),
        .en       ((state == ST_SETUP) || (state == ST_HOLD)),
        .load_val (dly_val),
        .zero     (dly_zero)
    );
`else
    logic unused_dly;

    assign unused_dly = ^sif.dly_i;
    assign go_setup   = 1'b0;
    assign go_hold    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= ST_IDLE;
            edges_left <= '0;
            sck_r      <= 1'b0;
            cs_n_r     <= 1'b1;
            busy_r     <= 1'b0;
            sample_r   <= 1'b0;
            shift_r    <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            sample_r <= 1'b0;
            shift_r  <= 1'b0;
            done_r   <= 1'b0;
            if (sif.abort_i) begin
                state  <= ST_IDLE;
                sck_r  <= sif.cpol_i;
                cs_n_r <= 1'b1;
                busy_r <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        sck_r <= sif.cpol_i;
                        if (sif.start_i) begin
                            cs_n_r     <= 1'b0;
                            busy_r     <= 1'b1;
                            edges_left <= edge_total(sif.len_i);
                            state      <= go_setup ? ST_SETUP : ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (half_zero) begin
                            if (edges_left != '0) begin
                                sck_r      <= ~sck_r;
                                edges_left <= edges_left - EDGE_W'(1);
                                if (cfg_cpha) begin
                                    shift_r  <= lead_edge;
                                    sample_r <= ~lead_edge;
                                end else begin
                                    sample_r <= lead_edge;
                                    shift_r  <= ~lead_edge & ~last_edge;
                                end
                            end else if (go_hold) begin
                                state <= ST_HOLD;
                            end else begin
                                state  <= ST_IDLE;
                                cs_n_r <= 1'b1;
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                            end
                        end
                    end
`ifdef SPI_SCKGEN_CSDLY_EN
                    ST_SETUP: begin
                        if (dly_zero) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_HOLD: begin
                        if (dly_zero) begin
                            state  <= ST_IDLE;
                            cs_n_r <= 1'b1;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign sif.sck_o    = sck_r;
    assign sif.cs_n_o   = cs_n_r;
    assign sif.busy_o   = busy_r;
    assign sif.sample_o = sample_r;
    assign sif.shift_o  = shift_r;
    assign sif.done_o   = done_r;

endmodule

// File: tb/tb_spi_sckgen.sv
// tb_spi_sckgen: directed self-checking bench for spi_sckgen (8-bit and 10-bit divider instances).
module tb_spi_sckgen;

    logic       clk;
    logic       rst_n;
    logic       start_r;
    logic       abort_r;
    logic       cpol_r;
    logic       cpha_r;
    logic       sel;
    logic [9:0] div_r;
    logic [4:0] len_r;
    logic [3:0] dly_r;

    int   n_chk;
    int   n_pass;
    int   edge_q[$];
    int   samp_q[$];
    int   shift_q[$];
    int   exp_q[$];
    logic lvl_q[$];
    int   done_cyc;
    int   busy_cyc;
    int   cs_cyc;
    logic busy_at_done;
    logic cs_at_done;

    logic m_sck, m_cs_n, m_busy, m_sample, m_shift, m_done;

    spi_sckgen_if #(.DIV_WIDTH(8),  .LEN_WIDTH(5), .DLY_WIDTH(4)) ifa ();
    spi_sckgen_if #(.DIV_WIDTH(10), .LEN_WIDTH(5), .DLY_WIDTH(4)) ifb ();

    assign ifa.start_i = start_r & ~sel;
    assign ifa.abort_i = abort_r;
    assign ifa.cpol_i  = cpol_r;
    assign ifa.cpha_i  = cpha_r;
    assign ifa.div_i   = div_r[7:0];
    assign ifa.len_i   = len_r;
    assign ifa.dly_i   = dly_r;
    assign ifb.start_i = start_r & sel;
    assign ifb.abort_i = abort_r;
    assign ifb.cpol_i  = cpol_r;
    assign ifb.cpha_i  = cpha_r;
    assign ifb.div_i   = div_r;
    assign ifb.len_i   = len_r;
    assign ifb.dly_i   = dly_r;

    spi_sckgen #(.DIV_WIDTH(8),  .LEN_WIDTH(5), .DLY_WIDTH(4)) dut_a (.clk_i(clk), .rst_n_i(rst_n), .sif(ifa));
    spi_sckgen #(.DIV_WIDTH(10), .LEN_WIDTH(5), .DLY_WIDTH(4)) dut_b (.clk_i(clk), .rst_n_i(rst_n), .sif(ifb));

    assign m_sck    = sel ? ifb.sck_o    : ifa.sck_o;
    assign m_cs_n   = sel ? ifb.cs_n_o   : ifa.cs_n_o;
    assign m_busy   = sel ? ifb.busy_o   : ifa.busy_o;
    assign m_sample = sel ? ifb.sample_o : ifa.sample_o;
    assign m_shift  = sel ? ifb.shift_o  : ifa.shift_o;
    assign m_done   = sel ? ifb.done_o   : ifa.done_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int first_diff(input int got[$], input int req[$]);
        if (got.size() != req.size()) begin
            for (int i = 0; i < got.size() && i < req.size(); i++)
                if (got[i] != req[i]) return i;
            return (got.size() < req.size()) ? got.size() : req.size();
        end
        foreach (got[i]) if (got[i] != req[i]) return i;
        return -1;
    endfunction

    function automatic int val_at(input int q[$], input int i);
        if (i < 0 || i >= q.size()) return -1;
        return q[i];
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Starts a frame in the current cycle (cycle 0) and logs events by cycle until done_o or limit.
    task automatic run_frame(input int limit, input int poke);
        logic       prev;
        logic       s_cpol, s_cpha;
        logic [9:0] s_div;
        logic [4:0] s_len;
        edge_q.delete(); samp_q.delete(); shift_q.delete(); lvl_q.delete();
        done_cyc = -1; busy_cyc = -1; cs_cyc = -1;
        busy_at_done = 1'bx; cs_at_done = 1'bx;
        s_cpol = cpol_r; s_cpha = cpha_r; s_div = div_r; s_len = len_r;
        prev = m_sck;
        lvl_q.push_back(m_sck);
        start_r = 1'b1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (c == 1) start_r = 1'b0;
            if (poke > 1 && c == poke) begin
                start_r = 1'b1; div_r = 10'd0; len_r = 5'd3; cpol_r = ~s_cpol; cpha_r = ~s_cpha;
            end
            if (poke > 1 && c == poke + 1) begin
                start_r = 1'b0; div_r = s_div; len_r = s_len; cpol_r = s_cpol; cpha_r = s_cpha;
            end
            lvl_q.push_back(m_sck);
            if (m_sck !== prev) edge_q.push_back(c);
            prev = m_sck;
            if (m_sample === 1'b1) samp_q.push_back(c);
            if (m_shift === 1'b1) shift_q.push_back(c);
            if (m_busy === 1'b1 && busy_cyc < 0) busy_cyc = c;
            if (m_cs_n === 1'b0 && cs_cyc < 0) cs_cyc = c;
            if (m_done === 1'b1) begin
                done_cyc = c; busy_at_done = m_busy; cs_at_done = m_cs_n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_r = 1'b0; abort_r = 1'b0; cpol_r = 1'b1; cpha_r = 1'b0;
        sel = 1'b0; div_r = 10'd0; len_r = 5'd0; dly_r = 4'd0;
        idle(3);
        n_chk++; if (m_sck !== 1'b0) $display("FAIL reset_sck: got %b required 0", m_sck); else n_pass++;
        n_chk++; if ({m_cs_n, m_busy} !== 2'b10) $display("FAIL reset_cs_busy: got %b required 10", {m_cs_n, m_busy}); else n_pass++;
        n_chk++; if ({m_sample, m_shift, m_done} !== 3'b000) $display("FAIL reset_strobes: got %b required 000", {m_sample, m_shift, m_done}); else n_pass++;
        rst_n = 1'b1;
        idle(1);
        n_chk++; if (m_sck !== 1'b1) $display("FAIL reset_sck_follows_cpol: got %b required 1", m_sck); else n_pass++;
    endtask

    task automatic test_mode0();
        int d;
        cpol_r = 1'b0; cpha_r = 1'b0; div_r = 10'd1; len_r = 5'd7; dly_r = 4'd0;
        idle(2);
        run_frame(60, 0);
        n_chk++; if (busy_cyc !== 1) $display("FAIL mode0_busy_rise: got %0d required 1", busy_cyc); else n_pass++;
        n_chk++; if (cs_cyc !== 1) $display("FAIL mode0_cs_fall: got %0d required 1", cs_cyc); else n_pass++;
        exp_q.delete(); for (int k = 1; k <= 16; k++) exp_q.push_back(1 + 2 * k);
        n_chk++; d = first_diff(edge_q, exp_q);
        if (d >= 0) $display("FAIL mode0_edges: at %0d got %0d required %0d", d, val_at(edge_q, d), val_at(exp_q, d)); else n_pass++;
        n_chk++; if (lvl_q.size() < 4 || lvl_q[3] !== 1'b1) $display("FAIL mode0_first_edge_rises: got %0d required 1", (lvl_q.size() < 4) ? -1 : int'(lvl_q[3])); else n_pass++;
        exp_q.delete(); for (int k = 1; k <= 16; k += 2) exp_q.push_back(1 + 2 * k);
        n_chk++; d = first_diff(samp_q, exp_q);
        if (d >= 0) $display("FAIL mode0_sample: at %0d got %0d required %0d", d, val_at(samp_q, d), val_at(exp_q, d)); else n_pass++;
        exp_q.delete(); for (int k = 2; k <= 14; k += 2) exp_q.push_back(1 + 2 * k);
        n_chk++; d = first_diff(shift_q, exp_q);
        if (d >= 0) $display("FAIL mode0_shift: at %0d got %0d required %0d", d, val_at(shift_q, d), val_at(exp_q, d)); else n_pass++;
        n_chk++; if (done_cyc !== 35) $display("FAIL mode0_done: got %0d required 35", done_cyc); else n_pass++;
        n_chk++; if ({busy_at_done, cs_at_done} !== 2'b01) $display("FAIL mode0_release_at_done: got %b required 01", {busy_at_done, cs_at_done}); else n_pass++;
    endtask

    task automatic test_mode3();
        int d;
        cpol_r = 1'b1; cpha_r = 1'b1; div_r = 10'd0; len_r = 5'd0; dly_r = 4'd0;
        idle(2);
        run_frame(20, 0);
        exp_q.delete(); exp_q.push_back(2); exp_q.push_back(3);
        n_chk++; d = first_diff(edge_q, exp_q);
        if (d >= 0) $display("FAIL mode3_edges: at %0d got %0d required %0d", d, val_at(edge_q, d), val_at(exp_q, d)); else n_pass++;
        n_chk++; if (lvl_q.size() < 4 || {lvl_q[1], lvl_q[2], lvl_q[3]} !== 3'b101) $display("FAIL mode3_levels: got size %0d required sck 1,0,1 at cycles 1..3", lvl_q.size()); else n_pass++;
        exp_q.delete(); exp_q.push_back(2);
        n_chk++; d = first_diff(shift_q, exp_q);
        if (d >= 0) $display("FAIL mode3_shift: at %0d got %0d required %0d", d, val_at(shift_q, d), val_at(exp_q, d)); else n_pass++;
        exp_q.delete(); exp_q.push_back(3);
        n_chk++; d = first_diff(samp_q, exp_q);
        if (d >= 0) $display("FAIL mode3_sample: at %0d got %0d required %0d", d, val_at(samp_q, d), val_at(exp_q, d)); else n_pass++;
        n_chk++; if (done_cyc !== 4) $display("FAIL mode3_done: got %0d required 4", done_cyc); else n_pass++;
    endtask

    // cpha=1 with cpol=0, plus a start pulse and scrambled inputs mid-frame that must be ignored.
    task automatic test_cpha1_latched();
        int d;
        cpol_r = 1'b0; cpha_r = 1'b1; div_r = 10'd2; len_r = 5'd1; dly_r = 4'd0;
        idle(2);
        run_frame(40, 5);
        exp_q.delete(); for (int k = 1; k <= 4; k++) exp_q.push_back(1 + 3 * k);
        n_chk++; d = first_diff(edge_q, exp_q);
        if (d >= 0) $display("FAIL cpha1_edges: at %0d got %0d required %0d", d, val_at(edge_q, d), val_at(exp_q, d)); else n_pass++;
        exp_q.delete(); exp_q.push_back(4); exp_q.push_back(10);
        n_chk++; d = first_diff(shift_q, exp_q);
        if (d >= 0) $display("FAIL cpha1_shift: at %0d got %0d required %0d", d, val_at(shift_q, d), val_at(exp_q, d)); else n_pass++;
        exp_q.delete(); exp_q.push_back(7); exp_q.push_back(13);
        n_chk++; d = first_diff(samp_q, exp_q);
        if (d >= 0) $display("FAIL cpha1_sample: at %0d got %0d required %0d", d, val_at(samp_q, d), val_at(exp_q, d)); else n_pass++;
        n_chk++; if (done_cyc !== 16) $display("FAIL cpha1_done: got %0d required 16", done_cyc); else n_pass++;
    endtask

    task automatic test_abort();
        int bad;
        cpol_r = 1'b1; cpha_r = 1'b0; div_r = 10'd1; len_r = 5'd7; dly_r = 4'd0;
        idle(2);
        start_r = 1'b1;
        idle(1);
        start_r = 1'b0;
        idle(9);
        abort_r = 1'b1;
        idle(1);
        abort_r = 1'b0;
        n_chk++; if ({m_busy, m_cs_n, m_sck} !== 3'b011) $display("FAIL abort_state: got busy,cs_n,sck=%b required 011", {m_busy, m_cs_n, m_sck}); else n_pass++;
        n_chk++; if ({m_sample, m_shift, m_done} !== 3'b000) $display("FAIL abort_strobes: got %b required 000", {m_sample, m_shift, m_done}); else n_pass++;
        bad = 0;
        for (int c = 12; c <= 40; c++) begin
            idle(1);
            if (m_done !== 1'b0 || m_busy !== 1'b0) bad++;
        end
        n_chk++; if (bad !== 0) $display("FAIL abort_no_done: got %0d active cycles required 0", bad); else n_pass++;
        start_r = 1'b1; abort_r = 1'b1;
        idle(1);
        start_r = 1'b0; abort_r = 1'b0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (m_busy !== 1'b0 || m_cs_n !== 1'b1) bad++;
            idle(1);
        end
        n_chk++; if (bad !== 0) $display("FAIL abort_start_same_cycle: got %0d busy cycles required 0", bad); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d;
        cpol_r = 1'b0; cpha_r = 1'b0; div_r = 10'd0; len_r = 5'd0; dly_r = 4'd0;
        idle(2);
        run_frame(20, 0);
        n_chk++; if (done_cyc !== 4) $display("FAIL b2b_first_done: got %0d required 4", done_cyc); else n_pass++;
        idle(1);
        n_chk++; if ({m_cs_n, m_busy} !== 2'b10) $display("FAIL b2b_gap: got cs_n,busy=%b required 10", {m_cs_n, m_busy}); else n_pass++;
        run_frame(20, 0);
        n_chk++; if (cs_cyc !== 1 || busy_cyc !== 1) $display("FAIL b2b_second_start: got cs %0d busy %0d required 1 1", cs_cyc, busy_cyc); else n_pass++;
        exp_q.delete(); exp_q.push_back(2); exp_q.push_back(3);
        n_chk++; d = first_diff(edge_q, exp_q);
        if (d >= 0) $display("FAIL b2b_edges: at %0d got %0d required %0d", d, val_at(edge_q, d), val_at(exp_q, d)); else n_pass++;
        n_chk++; if (done_cyc !== 4) $display("FAIL b2b_second_done: got %0d required 4", done_cyc); else n_pass++;
    endtask

    task automatic test_delay();
        int d;
        int e1, e2, dn;
`ifdef SPI_SCKGEN_CSDLY_EN
        e1 = 5; e2 = 6; dn = 10;
`else
        e1 = 2; e2 = 3; dn = 4;
`endif
        cpol_r = 1'b0; cpha_r = 1'b0; div_r = 10'd0; len_r = 5'd0; dly_r = 4'd3;
        idle(2);
        run_frame(30, 0);
        n_chk++; if (cs_cyc !== 1) $display("FAIL dly_cs_fall: got %0d required 1", cs_cyc); else n_pass++;
        exp_q.delete(); exp_q.push_back(e1); exp_q.push_back(e2);
        n_chk++; d = first_diff(edge_q, exp_q);
        if (d >= 0) $display("FAIL dly_edges: at %0d got %0d required %0d", d, val_at(edge_q, d), val_at(exp_q, d)); else n_pass++;
        n_chk++; if (done_cyc !== dn) $display("FAIL dly_done: got %0d required %0d", done_cyc, dn); else n_pass++;
        dly_r = 4'd0;
    endtask

    task automatic test_reset_mid();
        int d;
        cpol_r = 1'b0; cpha_r = 1'b0; div_r = 10'd1; len_r = 5'd7; dly_r = 4'd0;
        idle(2);
        start_r = 1'b1;
        idle(1);
        start_r = 1'b0;
        idle(7);
        n_chk++; if ({m_busy, m_sck} !== 2'b11) $display("FAIL rstmid_pre: got busy,sck=%b required 11", {m_busy, m_sck}); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if ({m_sck, m_cs_n, m_busy, m_sample, m_shift, m_done} !== 6'b010000) $display("FAIL rstmid_async: got %b required 010000", {m_sck, m_cs_n, m_busy, m_sample, m_shift, m_done}); else n_pass++;
        idle(1);
        rst_n = 1'b1;
        idle(2);
        run_frame(60, 0);
        exp_q.delete(); for (int k = 1; k <= 16; k++) exp_q.push_back(1 + 2 * k);
        n_chk++; d = first_diff(edge_q, exp_q);
        if (d >= 0) $display("FAIL rstmid_edges: at %0d got %0d required %0d", d, val_at(edge_q, d), val_at(exp_q, d)); else n_pass++;
        n_chk++; if (done_cyc !== 35) $display("FAIL rstmid_done: got %0d required 35", done_cyc); else n_pass++;
    endtask

    task automatic test_long_div();
        int d;
        cpol_r = 1'b0; cpha_r = 1'b0; div_r = 10'd255; len_r = 5'd31; dly_r = 4'd0;
        idle(2);
        run_frame(17000, 0);
        exp_q.delete(); for (int k = 1; k <= 64; k++) exp_q.push_back(1 + 256 * k);
        n_chk++; d = first_diff(edge_q, exp_q);
        if (d >= 0) $display("FAIL div255_edges: at %0d got %0d required %0d (n=%0d)", d, val_at(edge_q, d), val_at(exp_q, d), edge_q.size()); else n_pass++;
        n_chk++; if (samp_q.size() !== 32 || shift_q.size() !== 31) $display("FAIL div255_strobe_count: got %0d/%0d required 32/31", samp_q.size(), shift_q.size()); else n_pass++;
        n_chk++; if (done_cyc !== 16641) $display("FAIL div255_done: got %0d required 16641", done_cyc); else n_pass++;
    endtask

    task automatic test_wide_div();
        int d;
        sel = 1'b1;
        cpol_r = 1'b0; cpha_r = 1'b0; div_r = 10'd1023; len_r = 5'd1; dly_r = 4'd0;
        idle(2);
        run_frame(5200, 0);
        exp_q.delete(); for (int k = 1; k <= 4; k++) exp_q.push_back(1 + 1024 * k);
        n_chk++; d = first_diff(edge_q, exp_q);
        if (d >= 0) $display("FAIL div1023_edges: at %0d got %0d required %0d", d, val_at(edge_q, d), val_at(exp_q, d)); else n_pass++;
        n_chk++; if (done_cyc !== 5121) $display("FAIL div1023_done: got %0d required 5121", done_cyc); else n_pass++;
        sel = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        test_reset();
        test_mode0();
        test_mode3();
        test_cpha1_latched();
        test_abort();
        test_back_to_back();
        test_delay();
        test_reset_mid();
        test_long_div();
        test_wide_div();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_sckgen.md
# spi_sckgen

Parametrised SPI serial-clock and frame sequencer for the SPI master datapath. It replaces the fixed 8-bit divider clock generator. It generates SCK with programmable divider width, polarity and phase, and counts the bits of a frame of programmable length. It drives chip-select timing and emits phase-resolved sample/shift strobes, so the shift register needs no CPOL/CPHA logic of its own.

## Interface
Parameters:
- DIV_WIDTH, 8, width of the half-period divider.
- LEN_WIDTH, 5, width of the frame length field; frame holds len_i+1 bits.
- DLY_WIDTH, 4, width of the CS setup/hold delay fields.

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  frame request; sampled only in IDLE.
- abort_i  in  1  synchronous abort; any state returns to IDLE.
- cpol_i  in  1  SCK idle level.
- cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge.
- div_i  in  DIV_WIDTH  half-period = div_i+1 clk cycles.
- len_i  in  LEN_WIDTH  bits per frame minus one.
- dly_i  in  DLY_WIDTH  CS setup and hold cycles (used only with the macro).
- sck_o  out  1  serial clock.
- cs_n_o  out  1  active-low chip select.
- busy_o  out  1  frame in progress.
- sample_o  out  1  one-cycle strobe: capture MISO.
- shift_o  out  1  one-cycle strobe: drive next MOSI bit.
- done_o  out  1  one-cycle strobe: frame completed normally.

## Operation
- States: IDLE, SETUP, RUN, HOLD. SETUP and HOLD exist only with the macro.
- IDLE:
  - sck_o follows registered cpol_i.
  - cs_n_o=1, busy_o=0.
  - start_i latches cpol/cpha/div/len/dly. The next state is SETUP if the macro is enabled and dly≠0; otherwise it is RUN.
- SETUP: counts dly cycles, then goes to RUN.
- RUN:
  - A half-period counter loads div on entry and decrements each cycle.
  - At zero it reloads div. If edges_left>0, sck_o toggles and edges_left decrements. edges_left is loaded with 2*(len+1) and has width LEN_WIDTH+2.
  - When it reaches zero with edges_left==0 (one extra half-period after the last edge), the next state is HOLD if the macro is enabled and dly≠0; otherwise the frame ends.
- Edge classes: odd edges (1, 3, …) are leading; even edges are trailing.
- Strobes for cpha=0:
  - sample_o on every leading edge.
  - shift_o on every trailing edge except the last.
  - The first bit is driven by the host on the busy_o rise.
- Strobes for cpha=1:
  - shift_o on every leading edge.
  - sample_o on every trailing edge.
- HOLD: counts dly cycles with cs_n_o low and SCK at cpol.
- Frame end: done_o pulses one cycle. busy_o and cs_n_o deassert in the same cycle. The state returns to IDLE.
- start_i during a frame is ignored. Inputs changing mid-frame have no effect because all fields are latched.
- abort_i has priority over everything, including a simultaneous start_i:
  - Next cycle: IDLE, sck_o=cpol, cs_n_o=1, busy_o=0.
  - No done_o pulse; strobes are 0.

## Timing
- Reset values: sck_o=0, cs_n_o=1, busy_o=0, sample_o=0, shift_o=0, done_o=0, state IDLE. sck_o takes cpol_i one cycle after reset release.
- All outputs are registered.
- A strobe is high in the same cycle that sck_o first shows the new level.
- Let start_i be at cycle 0, with no delay, N=len+1 and H=div+1:
  - busy_o and cs_n_o go active at cycle 1.
  - SCK edge k (1..2N) is visible at cycle 1+k·H.
  - done_o is at cycle 1+(2N+1)·H.
- A non-zero delay of D cycles shifts the edges by D and done_o by 2D.
- div=0 gives a half-period of one cycle; edges occur on consecutive cycles with no special case.
- Back-to-back frames: start_i may be asserted in the done_o cycle's successor (IDLE). The minimum cs_n_o high time is 1 cycle.

## Configuration
- Macro: SPI_SCKGEN_CSDLY_EN.
- Defined: SETUP/HOLD states and the dly_i counter are present. cs_n_o leads the first edge and trails the last edge by dly extra cycles.
- Undefined: dly_i is unused and tied off internally. SETUP/HOLD are not generated. Timing equals the dly=0 case.

## Structure
- Shared package spi_pkg holds:
  - the state enum typedef spi_sckgen_state_e;
  - the localparam defaults for DIV_WIDTH, LEN_WIDTH and DLY_WIDTH.
- Sub-module spi_sckgen_cnt: a reloadable down-counter (load, enable, zero flag) parametrised by width. It is instantiated for the half-period counter and, with the macro, for the delay counter.

## Test plan
- cpol=0, cpha=0, div=1, len=7, start at cycle 0 -> busy at 1; rising edges at 3,7,…,31; sample_o at those cycles; shift_o at 5..29 (7 pulses); done at 35.
- cpol=1, cpha=1, div=0, len=0 -> sck 1→0 at 2, 0→1 at 3; shift_o at 2; sample_o at 3; done at 4.
- div=255 with DIV_WIDTH=10, div=1023 -> half-period of 256 and 1024 cycles respectively; edge count is exact for len=31 (64 edges).
- abort_i at cycle 10 of a div=1, len=7 frame -> cycle 11: busy_o=0, cs_n_o=1, sck_o=cpol; no done_o; abort+start in the same IDLE cycle -> no frame.
- Macro on, dly=3, div=0, len=0 -> cs_n_o low at 1; edges at 5,6; done at 10.
- Reset asserted mid-RUN -> all outputs immediately take their reset values; after release, a fresh start produces nominal timing.
